// File: rtl/mul_param_pkg.sv
// Shared types and sizing helpers for the handshaked shift-add multiplier.
package mul_param_pkg;

   // Control FSM states: collect operands, iterate, present result.
   typedef enum logic [1:0] {
      WAIT_OPS = 2'd0,
      MUL      = 2'd1,
      OUT      = 2'd2
   } state_t;

   // Width of an iteration counter that must be able to hold the value w.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/hs_rx.sv
// One receive channel: single-entry operand buffer with a data-available /
// ready-for-data handshake. The full flag is cleared by the consumer (clr_i)
// once the operand has been copied out, after which the channel re-opens as
// soon as the sender has released dav_n_i.
module hs_rx
   import mul_param_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] data_i,
   input  logic         dav_n_i,
   input  logic         clr_i,
   output logic         rfd_o,
   output logic         full_o,
   output logic [W-1:0] buf_o
);

   logic         rfd_q;
   logic         rfd_d;
   logic         full_q;
   logic         full_d;
   logic [W-1:0] buf_q;
   logic [W-1:0] buf_d;
   logic         take_s;

   // Next-state logic: capture on an open channel, clear on consume, re-open
   // only when the sender is idle and the buffer has been drained.
   always_comb begin
      take_s = rfd_q & ~dav_n_i;
      buf_d  = buf_q;
      full_d = full_q;
      rfd_d  = rfd_q;
      if (take_s) begin
         buf_d  = data_i;
         full_d = 1'b1;
         rfd_d  = 1'b0;
      end else begin
         if (clr_i) begin
            full_d = 1'b0;
         end else begin
            full_d = full_q;
         end
         if (!rfd_q && dav_n_i && !full_q) begin
            rfd_d = 1'b1;
         end else begin
            rfd_d = rfd_q;
         end
      end
   end

   // Channel state registers with synchronous reset to an open, empty channel.
   always_ff @(posedge clock) begin
      if (reset) begin
         rfd_q  <= 1'b1;
         full_q <= 1'b0;
         buf_q  <= '0;
      end else begin
         rfd_q  <= rfd_d;
         full_q <= full_d;
         buf_q  <= buf_d;
      end
   end

   assign rfd_o  = rfd_q;
   assign full_o = full_q;
   assign buf_o  = buf_q;

endmodule

// File: rtl/mul_param.sv
// Handshaked W x W multiplier. Two hs_rx channels buffer the operands; a
// three-state FSM loads them into a serial shift-add datapath (one partial
// product per cycle) and presents the 2W-bit product until acknowledged.
// Signed mode multiplies magnitudes and applies the sign at the end, so the
// most-negative squared case fits without overflow.
module mul_param
   import mul_param_pkg::*;
#(
   parameter int W      = 8,
   parameter int SIGNED = 0
) (
   input  logic           clock,
   input  logic           reset,
   input  logic [W-1:0]   x,
   input  logic           dav1_,
   output logic           rfd1,
   input  logic [W-1:0]   y,
   input  logic           dav2_,
   output logic           rfd2,
   output logic [2*W-1:0] m,
   output logic           ok,
   input  logic           ack
);

   localparam int            CW   = cnt_width(W);
   localparam logic [CW-1:0] ITER = CW'(W);

   // Channel interface
   logic           full1_s;
   logic           full2_s;
   logic [W-1:0]   buf1_s;
   logic [W-1:0]   buf2_s;
   logic           load_s;

   // Operand conditioning
   logic [W-1:0]   mag1_s;
   logic [W-1:0]   mag2_s;
   logic           sgn_s;

   // Datapath and control state
   state_t         state_q;
   state_t         state_d;
   logic [2*W-1:0] acc_q;
   logic [2*W-1:0] acc_d;
   logic [2*W-1:0] mcand_q;
   logic [2*W-1:0] mcand_d;
   logic [W-1:0]   mplier_q;
   logic [W-1:0]   mplier_d;
   logic [CW-1:0]  cnt_q;
   logic [CW-1:0]  cnt_d;
   logic           neg_q;
   logic           neg_d;
   logic [2*W-1:0] m_q;
   logic [2*W-1:0] m_d;
   logic           ok_q;
   logic           ok_d;

   hs_rx #(.W(W)) u_rx1 (
      .clock   (clock),
      .reset   (reset),
      .data_i  (x),
      .dav_n_i (dav1_),
      .clr_i   (load_s),
      .rfd_o   (rfd1),
      .full_o  (full1_s),
      .buf_o   (buf1_s)
   );

   hs_rx #(.W(W)) u_rx2 (
      .clock   (clock),
      .reset   (reset),
      .data_i  (y),
      .dav_n_i (dav2_),
      .clr_i   (load_s),
      .rfd_o   (rfd2),
      .full_o  (full2_s),
      .buf_o   (buf2_s)
   );

   // Operand magnitudes and result sign; raw operands in unsigned mode.
   // Negating -2^(W-1) yields the same bit pattern, which read unsigned is
   // exactly the required magnitude 2^(W-1).
   always_comb begin
      mag1_s = buf1_s;
      mag2_s = buf2_s;
      sgn_s  = 1'b0;
      if (SIGNED != 0) begin
         sgn_s = buf1_s[W-1] ^ buf2_s[W-1];
         if (buf1_s[W-1]) begin
            mag1_s = ~buf1_s + W'(1);
         end else begin
            mag1_s = buf1_s;
         end
         if (buf2_s[W-1]) begin
            mag2_s = ~buf2_s + W'(1);
         end else begin
            mag2_s = buf2_s;
         end
      end else begin
         sgn_s = 1'b0;
      end
   end

   // Control FSM next-state and datapath update. MUL spends W cycles adding
   // partial products plus one cycle (counter == W) to register the result,
   // giving W+2 edges from the later capture to ok.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      m_d      = m_q;
      ok_d     = ok_q;
      load_s   = 1'b0;
      case (state_q)
         WAIT_OPS: begin
            if (full1_s && full2_s) begin
               load_s   = 1'b1;
               acc_d    = '0;
               mcand_d  = {{W{1'b0}}, mag1_s};
               mplier_d = mag2_s;
               cnt_d    = '0;
               neg_d    = sgn_s;
               state_d  = MUL;
            end else begin
               state_d  = WAIT_OPS;
            end
         end
         MUL: begin
            if (cnt_q == ITER) begin
               if (neg_q) begin
                  m_d = ~acc_q + {{(2*W-1){1'b0}}, 1'b1};
               end else begin
                  m_d = acc_q;
               end
               ok_d    = 1'b1;
               state_d = OUT;
            end else begin
               if (mplier_q[0]) begin
                  acc_d = acc_q + mcand_q;
               end else begin
                  acc_d = acc_q;
               end
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + CW'(1);
               state_d  = MUL;
            end
         end
         OUT: begin
            if (ack) begin
               ok_d    = 1'b0;
               state_d = WAIT_OPS;
            end else begin
               ok_d    = 1'b1;
               state_d = OUT;
            end
         end
         default: begin
            ok_d    = 1'b0;
            state_d = WAIT_OPS;
         end
      endcase
   end

   // Control and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= WAIT_OPS;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         m_q      <= '0;
         ok_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         m_q      <= m_d;
         ok_q     <= ok_d;
      end
   end

   assign m  = m_q;
   assign ok = ok_q;

endmodule

// File: tb/tb_mul_param.sv
// Directed bench for mul_param: one unsigned and one signed instance (W=8).
module tb_mul_param;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  x_a [2];
   logic [7:0]  y_a [2];
   logic [1:0]  dav1_a = 2'b11;
   logic [1:0]  dav2_a = 2'b11;
   logic [1:0]  rfd1_a;
   logic [1:0]  rfd2_a;
   logic [15:0] m_a [2];
   logic [1:0]  ok_a;
   logic [1:0]  ack_a = 2'b11;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          cap_cyc = 0;
   int          rise_cyc [2];
   bit [1:0]    okp = 2'b00;
   logic [15:0] q0 [$];
   logic [15:0] q1 [$];

   typedef struct {
      int          sel;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] exp;
   } vec_t;
   vec_t vecs [11];

   mul_param #(.W(8), .SIGNED(0)) u_dut_u (
      .clock(clock), .reset(reset),
      .x(x_a[0]), .dav1_(dav1_a[0]), .rfd1(rfd1_a[0]),
      .y(y_a[0]), .dav2_(dav2_a[0]), .rfd2(rfd2_a[0]),
      .m(m_a[0]), .ok(ok_a[0]), .ack(ack_a[0])
   );

   mul_param #(.W(8), .SIGNED(1)) u_dut_s (
      .clock(clock), .reset(reset),
      .x(x_a[1]), .dav1_(dav1_a[1]), .rfd1(rfd1_a[1]),
      .y(y_a[1]), .dav2_(dav2_a[1]), .rfd2(rfd2_a[1]),
      .m(m_a[1]), .ok(ok_a[1]), .ack(ack_a[1])
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Result monitor: note ok rise edge, record each acknowledged result.
   always @(negedge clock) begin
      for (int s = 0; s < 2; s++) begin
         if (ok_a[s] && !okp[s]) rise_cyc[s] = cyc;
         okp[s] = ok_a[s];
         if (ok_a[s] && ack_a[s]) begin
            if (s == 0) q0.push_back(m_a[0]);
            else        q1.push_back(m_a[1]);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic send(input int sel, input int ch, input logic [7:0] v);
      int n = 0;
      @(negedge clock);
      while (((ch == 0) ? rfd1_a[sel] : rfd2_a[sel]) !== 1'b1 && n < 300) begin
         @(negedge clock);
         n++;
      end
      if (n >= 300) begin
         chk("send_timeout", 32'd1, 32'd0);
      end else begin
         if (ch == 0) begin x_a[sel] = v; dav1_a[sel] = 1'b0; end
         else         begin y_a[sel] = v; dav2_a[sel] = 1'b0; end
         @(posedge clock);
         #1;
         dav1_a[sel] = 1'b1;
         dav2_a[sel] = 1'b1;
         cap_cyc = cyc;
      end
   endtask

   task automatic send_both(input int sel, input logic [7:0] a, input logic [7:0] b);
      int n = 0;
      @(negedge clock);
      while (!(rfd1_a[sel] === 1'b1 && rfd2_a[sel] === 1'b1) && n < 300) begin
         @(negedge clock);
         n++;
      end
      if (n >= 300) begin
         chk("send_both_timeout", 32'd1, 32'd0);
      end else begin
         x_a[sel] = a; y_a[sel] = b;
         dav1_a[sel] = 1'b0; dav2_a[sel] = 1'b0;
         @(posedge clock);
         #1;
         dav1_a[sel] = 1'b1; dav2_a[sel] = 1'b1;
         cap_cyc = cyc;
      end
   endtask

   task automatic get_result(input int sel, output logic [15:0] r, output bit got);
      int n = 0;
      got = 1'b0;
      r   = '0;
      while (((sel == 0) ? q0.size() : q1.size()) == 0 && n < 400) begin
         @(negedge clock);
         n++;
      end
      if (((sel == 0) ? q0.size() : q1.size()) == 0) begin
         chk("result_timeout", 32'd1, 32'd0);
      end else begin
         got = 1'b1;
         if (sel == 0) r = q0.pop_front();
         else          r = q1.pop_front();
      end
   endtask

   task automatic run_pair(input int sel, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp, input string name);
      logic [15:0] r;
      bit          got;
      send(sel, 0, a);
      send(sel, 1, b);
      get_result(sel, r, got);
      if (got) begin
         chk({name, "_m"}, 32'(r), 32'(exp));
         chk({name, "_lat"}, 32'(rise_cyc[sel] - cap_cyc), 32'd10);
      end
   endtask

   initial begin
      logic [15:0] r;
      bit          got;
      bit          bad;
      int          e;
      int          n;

      x_a[0] = '0; x_a[1] = '0; y_a[0] = '0; y_a[1] = '0;

      vecs[0]  = '{0, 8'd5,   8'd28,  16'd140};
      vecs[1]  = '{0, 8'd255, 8'd255, 16'd65025};
      vecs[2]  = '{0, 8'd0,   8'd200, 16'd0};
      vecs[3]  = '{0, 8'd1,   8'd255, 16'd255};
      vecs[4]  = '{0, 8'd16,  8'd16,  16'd256};
      vecs[5]  = '{1, 8'h80,  8'h80,  16'd16384};
      vecs[6]  = '{1, 8'hFD,  8'd7,   16'hFFEB};
      vecs[7]  = '{1, 8'd127, 8'h80,  16'hC080};
      vecs[8]  = '{1, 8'hFF,  8'hFF,  16'd1};
      vecs[9]  = '{1, 8'd0,   8'hFB,  16'd0};
      vecs[10] = '{1, 8'd127, 8'd127, 16'h3F01};

      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      // Reset state
      @(negedge clock);
      chk("rst_rfd1", 32'(rfd1_a[0]), 32'd1);
      chk("rst_rfd2", 32'(rfd2_a[0]), 32'd1);
      chk("rst_ok",   32'(ok_a[0]),   32'd0);
      chk("rst_m",    32'(m_a[0]),    32'd0);
      chk("rst_ok_s", 32'(ok_a[1]),   32'd0);
      chk("rst_m_s",  32'(m_a[1]),    32'd0);

      // Table-driven products
      for (int i = 0; i < 11; i++) begin
         run_pair(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // Both operands captured on the same edge
      send_both(0, 8'd9, 8'd9);
      get_result(0, r, got);
      if (got) begin
         chk("same_edge_m", 32'(r), 32'd81);
         chk("same_edge_lat", 32'(rise_cyc[0] - cap_cyc), 32'd10);
      end

      // Back-to-back: second pair buffered during MUL
      send(0, 0, 8'd5);
      send(0, 1, 8'd28);
      e = cap_cyc;
      repeat (2) @(posedge clock);
      send(0, 0, 8'd11);
      send(0, 1, 8'd13);
      bad = 1'b0;
      do begin
         @(negedge clock);
         if (rfd1_a[0] !== 1'b0 || rfd2_a[0] !== 1'b0) bad = 1'b1;
      end while (cyc < e + 11);
      chk("b2b_rfd_held", 32'(bad), 32'd0);
      get_result(0, r, got);
      if (got) chk("b2b_first", 32'(r), 32'd140);
      get_result(0, r, got);
      if (got) chk("b2b_second", 32'(r), 32'd143);

      // Result held while ack is low
      ack_a[0] = 1'b0;
      send(0, 0, 8'd7);
      send(0, 1, 8'd6);
      n = 0;
      while (ok_a[0] !== 1'b1 && n < 50) begin
         @(negedge clock);
         n++;
      end
      chk("hold_ok_seen", 32'(ok_a[0]), 32'd1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         chk($sformatf("hold_ok_%0d", k), 32'(ok_a[0]), 32'd1);
         chk($sformatf("hold_m_%0d", k),  32'(m_a[0]),  32'd42);
      end
      @(posedge clock);
      #1 ack_a[0] = 1'b1;
      @(posedge clock);
      @(negedge clock);
      chk("ack_ok_low", 32'(ok_a[0]), 32'd0);
      chk("ack_m_kept", 32'(m_a[0]),  32'd42);
      get_result(0, r, got);
      if (got) chk("hold_result", 32'(r), 32'd42);

      // Reset in the middle of MUL
      send(0, 0, 8'd100);
      send(0, 1, 8'd100);
      repeat (4) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("mrst_ok",   32'(ok_a[0]),   32'd0);
      chk("mrst_rfd1", 32'(rfd1_a[0]), 32'd1);
      chk("mrst_rfd2", 32'(rfd2_a[0]), 32'd1);
      repeat (20) @(negedge clock);
      chk("mrst_no_result", 32'(q0.size()), 32'd0);
      q0.delete();
      run_pair(0, 8'd12, 8'd35, 16'd420, "post_rst");

      // Skewed arrival: x waits 20 cycles for y
      send(0, 0, 8'd20);
      repeat (20) @(posedge clock);
      send(0, 1, 8'd30);
      get_result(0, r, got);
      if (got) begin
         chk("skew_m", 32'(r), 32'd600);
         chk("skew_lat", 32'(rise_cyc[0] - cap_cyc), 32'd10);
      end

      // 60-pair sweep with results collected by the monitor
      for (int i = 0; i < 60; i++) begin
         send(0, 0, 8'((i / 4 + 1) * 5));
         send(0, 1, 8'((i % 4 + 4) * 7));
      end
      n = 0;
      while (q0.size() < 60 && n < 2000) begin
         @(negedge clock);
         n++;
      end
      repeat (30) @(negedge clock);
      chk("sweep_count", 32'(q0.size()), 32'd60);
      for (int i = 0; i < 60; i++) begin
         if (q0.size() > 0) begin
            r = q0.pop_front();
            chk($sformatf("sweep_%0d", i), 32'(r), 32'((i / 4 + 1) * 5 * (i % 4 + 4) * 7));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global time limit
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mul_param.md
MUL_PARAM -- requirements
Module: mul_param

Interface
REQ-001 Parameter W, default 8: operand width in bits, W >= 2.
REQ-002 Parameter SIGNED, default 0: 0 = unsigned operands, 1 = two's-complement operands.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 x  input  W  operand 1, valid while dav1_ = 0.
REQ-006 dav1_  input  1  operand 1 data-available, active low.
REQ-007 rfd1  output  1  operand 1 ready-for-data.
REQ-008 y  input  W  operand 2, valid while dav2_ = 0.
REQ-009 dav2_  input  1  operand 2 data-available, active low.
REQ-010 rfd2  output  1  operand 2 ready-for-data.
REQ-011 m  output  2W  product; SIGNED=1 gives two's complement.
REQ-012 ok  output  1  result valid; held until acknowledged.
REQ-013 ack  input  1  result consumed, active high.

Function
REQ-014 Each channel SHALL, at an edge with rfd = 1 and dav_ = 0, capture its operand into a channel buffer, set a per-channel full flag and drive rfd to 0.
REQ-015 Each channel SHALL ignore dav_ while rfd = 0.
REQ-016 A channel SHALL drive rfd back to 1 only when dav_ = 1 and its full flag is clear; both conditions are required.
REQ-017 The control FSM SHALL have exactly three states: WAIT_OPS, MUL and OUT.
REQ-018 In WAIT_OPS with both full flags set, the FSM SHALL load the multiplier, clear both full flags and go to MUL on the same edge.
REQ-019 The load SHALL take operand magnitudes and result sign when SIGNED = 1, and raw operands when SIGNED = 0.
REQ-020 MUL SHALL run exactly W shift-add iterations, one per cycle, on a 2W-bit accumulator, then go to OUT.
REQ-021 On entry to OUT, the FSM SHALL register m (negated if the sign is negative) and set ok = 1.
REQ-022 The sequence SHALL take exactly W+2 rising edges from the edge capturing the later operand to the edge that sets ok.
REQ-023 In OUT, m and ok SHALL hold stable until ack = 1 is sampled; that edge SHALL clear ok and go to WAIT_OPS.
REQ-024 ack SHALL be ignored outside OUT.
REQ-025 While the FSM is in MUL or OUT, each channel SHALL accept its next operand, buffering at most one operand per channel.
REQ-026 If the operands arrive on different edges, the earlier operand SHALL wait buffered with no limit.
REQ-027 If both operands are captured on the same edge, the load SHALL occur on the next edge.
REQ-028 SIGNED = 1 with both operands at most negative (-2^(W-1)) SHALL give +2^(2W-2) without overflow.
REQ-029 m SHALL keep its last value after ok falls.

Reset
REQ-030 reset = 1 at an edge SHALL set state = WAIT_OPS, rfd1 = rfd2 = 1, ok = 0, m = 0, both full flags cleared and the accumulator and counter cleared.
REQ-031 Reset during MUL or OUT SHALL discard the operation in progress and all buffered operands, and SHALL produce no ok pulse.
REQ-032 reset SHALL take priority over every other input on the same edge.

Structure
REQ-033 Package mul_param_pkg SHALL hold the FSM state type (WAIT_OPS, MUL, OUT) and the iteration-counter width function clog2(W+1).
REQ-034 Per-channel capture logic SHALL be one sub-module, hs_rx, parametrised by W and instantiated twice; it provides the buffer, the full flag, the rfd logic and a clear input driven by the FSM load.
REQ-035 The multiplier datapath and FSM SHALL be in mul_param; the RTL is 120-400 lines in total.

Verification
REQ-036 W=8, SIGNED=0: x=5, y=28, ack=1 when ok rises -> m=140; ok rises exactly 10 edges after the later capture.
REQ-037 W=8, SIGNED=0: x=255, y=255 -> m=65025; W=8, SIGNED=1: x=-128, y=-128 -> m=16384; x=-3, y=7 -> m=16'hFFEB.
REQ-038 Back-to-back: present the second operand pair during MUL -> rfd1 and rfd2 stay 0 until the load edge, and the two results come out in order.
REQ-039 Hold ack=0 for 10 cycles after ok rises -> ok and m stay stable; ack=1 -> ok is 0 the next cycle.
REQ-040 reset=1 for one cycle mid-MUL -> ok=0, rfd1=rfd2=1, no result; the next operand pair x=12, y=35 -> m=420.
REQ-041 Skewed arrival (x 20 cycles before y) and 60-pair sweep x=(i/4+1)*5, y=(i%4+4)*7 -> every m correct and no lost or duplicated results.
